// File: rtl/svc_ice40_sram_io_pipe_if.sv
// Pipelined async-SRAM command interface: back-to-back reads, byte-lane writes,
// read->write turnaround and a credit-guarded in-order response FIFO.
module svc_ice40_sram_io_pipe_if #(
  parameter int SRAM_ADDR_WIDTH      = 18,
  parameter int SRAM_DATA_WIDTH      = 16,
  parameter int SRAM_STRB_WIDTH      = SRAM_DATA_WIDTH / 8,
  parameter int RESP_FIFO_ADDR_WIDTH = 2,
  parameter int RD_LATENCY           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sram_cmd_valid,
  output logic                       sram_cmd_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
  input  logic                       sram_cmd_wr_en,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_cmd_wr_data,
  input  logic [SRAM_STRB_WIDTH-1:0] sram_cmd_wr_strb,
  output logic                       sram_resp_rd_valid,
  input  logic                       sram_resp_rd_ready,
  output logic [SRAM_DATA_WIDTH-1:0] sram_resp_rd_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_io_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] sram_io_data,
  output logic                       sram_io_we_n,
  output logic                       sram_io_oe_n,
  output logic                       sram_io_ce_n,
  output logic [SRAM_STRB_WIDTH-1:0] sram_io_be_n
);

  localparam int FAW = RESP_FIFO_ADDR_WIDTH;
  localparam logic [FAW:0] L_DEPTH = {1'b1, {FAW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_READ, S_TURN, S_WRITE, S_WHOLD} state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic                         r_ready_en;
  logic [SRAM_ADDR_WIDTH-1:0]   r_addr;
  logic [SRAM_DATA_WIDTH-1:0]   r_wdata;
  logic [SRAM_STRB_WIDTH-1:0]   r_strb;
  logic [FAW:0]                 r_credits;

  logic                         w_accept;
  logic                         w_rd_acc;
  logic                         w_wr_acc;
  logic                         w_pop;

  logic                         w_pad_oe_n;
  logic                         w_pad_we_n;
  logic                         w_pad_drive;
  logic                         w_pad_rd_valid;
  logic [SRAM_STRB_WIDTH-1:0]   w_pad_be_n;

  logic [SRAM_ADDR_WIDTH-1:0]   r_io_addr;
  logic [SRAM_DATA_WIDTH-1:0]   r_io_wdata;
  logic                         r_io_we_n;
  logic                         r_io_oe_n;
  logic                         r_io_ce_n;
  logic                         r_io_drive;
  logic [SRAM_STRB_WIDTH-1:0]   r_io_be_n;

  logic [RD_LATENCY-2:0]        r_rd_vld;
  logic [SRAM_DATA_WIDTH-1:0]   r_rd_din [RD_LATENCY-2];

  logic [SRAM_DATA_WIDTH-1:0]   r_fifo [2**FAW];
  logic [FAW:0]                 r_wr_ptr;
  logic [FAW:0]                 r_rd_ptr;
  logic                         w_fifo_wr;

  // Ready depends only on registered state, never on valid or wr_en.
  assign sram_cmd_ready = r_ready_en && (r_credits < L_DEPTH) &&
                          (r_state == S_IDLE || r_state == S_READ || r_state == S_WHOLD);
  assign w_accept = sram_cmd_valid && sram_cmd_ready;
  assign w_rd_acc = w_accept && !sram_cmd_wr_en;
  assign w_wr_acc = w_accept && sram_cmd_wr_en && (|sram_cmd_wr_strb);
  assign w_pop    = sram_resp_rd_valid && sram_resp_rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ready_en <= 1'b0;
      r_credits  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready_en <= 1'b1;
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc || w_wr_acc) begin
      r_addr  <= sram_cmd_addr;
      r_wdata <= sram_cmd_wr_data;
      r_strb  <= sram_cmd_wr_strb;
    end
  end

  // Zero-strobe writes are swallowed: treated as if no command arrived.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_READ, S_WHOLD: begin
        if (w_rd_acc)      w_state_next = S_READ;
        else if (w_wr_acc) w_state_next = (r_state == S_READ) ? S_TURN : S_WRITE;
        else               w_state_next = S_IDLE;
      end
      S_TURN:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_WHOLD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pad_oe_n     = (r_state != S_READ);
    w_pad_we_n     = (r_state != S_WRITE);
    w_pad_drive    = (r_state == S_WRITE) || (r_state == S_WHOLD);
    w_pad_rd_valid = (r_state == S_READ);
    w_pad_be_n     = '1;
    if (r_state == S_READ) w_pad_be_n = '0;
    else if (w_pad_drive)  w_pad_be_n = ~r_strb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_we_n  <= 1'b1;
      r_io_oe_n  <= 1'b1;
      r_io_ce_n  <= 1'b1;
      r_io_drive <= 1'b0;
      r_io_be_n  <= '1;
      r_rd_vld   <= '0;
    end else begin
      r_io_we_n  <= w_pad_we_n;
      r_io_oe_n  <= w_pad_oe_n;
      r_io_ce_n  <= 1'b0;
      r_io_drive <= w_pad_drive;
      r_io_be_n  <= w_pad_be_n;
      r_rd_vld   <= {r_rd_vld[RD_LATENCY-3:0], w_pad_rd_valid};
    end
  end

  // Read data is sampled the edge after oe_n reaches the pins, then aligned
  // with the valid chain so the FIFO write lands RD_LATENCY edges after acceptance.
  always_ff @(posedge clk) begin
    r_io_addr   <= r_addr;
    r_io_wdata  <= r_wdata;
    r_rd_din[0] <= sram_io_data;
    for (int unsigned i = 1; i < unsigned'(RD_LATENCY - 2); i++) begin
      r_rd_din[i] <= r_rd_din[i-1];
    end
  end

  assign sram_io_addr = r_io_addr;
  assign sram_io_we_n = r_io_we_n;
  assign sram_io_oe_n = r_io_oe_n;
  assign sram_io_ce_n = r_io_ce_n;
  assign sram_io_be_n = r_io_be_n;
  assign sram_io_data = r_io_drive ? r_io_wdata : 'z;

  assign w_fifo_wr          = r_rd_vld[RD_LATENCY-2];
  assign sram_resp_rd_valid = (r_wr_ptr != r_rd_ptr);
  assign sram_resp_rd_data  = r_fifo[r_rd_ptr[FAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_fifo[r_wr_ptr[FAW-1:0]] <= r_rd_din[RD_LATENCY-3];
  end

endmodule
